// File: rtl/edge_gen_if.sv
// edge_gen request/status bundle.
// rise_req/down_req in; a, busy, done, err out.
interface edge_gen_if;
  logic rise_req;
  logic down_req;
  logic a;
  logic busy;
  logic done;
  logic err;

  modport master (
    output rise_req,
    output down_req,
    input  a,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  rise_req,
    input  down_req,
    output a,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/edge_gen.sv
// Edge generator with minimum high/low hold times.
// Ports: clk, rst (sync, active-high), bus (edge_gen_if.slave).
// Option: EDGE_GEN_PENDING_EN latches one opposite request during a hold.
module edge_gen #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input logic        clk,
  input logic        rst,
  edge_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    LOW_IDLE,
    HIGH_HOLD,
    HIGH_IDLE,
    LOW_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] HI_LD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LO_LD = CNT_W'(MIN_LOW - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             rise;
  logic             down;
  logic             pend_v;

  assign rise = bus.rise_req;
  assign down = bus.down_req;

`ifdef EDGE_GEN_PENDING_EN
  logic pend_q;
  assign pend_v = pend_q;
`else
  assign pend_v = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW_IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef EDGE_GEN_PENDING_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        LOW_IDLE: begin
          if (down) begin
            err_q <= 1'b1;
          end else if (rise) begin
            state_q <= HIGH_HOLD;
            cnt_q   <= HI_LD;
            a_q     <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH_IDLE: begin
          if (rise) begin
            err_q <= 1'b1;
          end else if (down) begin
            state_q <= LOW_HOLD;
            cnt_q   <= LO_LD;
            a_q     <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
`ifdef EDGE_GEN_PENDING_EN
            if (down && !rise && !pend_q)
              pend_q <= 1'b1;
            else if (rise || down)
              err_q <= 1'b1;
`else
            err_q <= rise || down;
`endif
          end else if (pend_v || (down && !rise)) begin
            // Last hold cycle: the edge lands next cycle,
            // whether from the latch or a fresh request.
            state_q <= LOW_HOLD;
            cnt_q   <= LO_LD;
            a_q     <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= pend_v && (rise || down);
`ifdef EDGE_GEN_PENDING_EN
            pend_q  <= 1'b0;
`endif
          end else begin
            state_q <= HIGH_IDLE;
            busy_q  <= 1'b0;
            err_q   <= rise || down;
          end
        end
        LOW_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
`ifdef EDGE_GEN_PENDING_EN
            if (rise && !down && !pend_q)
              pend_q <= 1'b1;
            else if (rise || down)
              err_q <= 1'b1;
`else
            err_q <= rise || down;
`endif
          end else if (pend_v || (rise && !down)) begin
            state_q <= HIGH_HOLD;
            cnt_q   <= HI_LD;
            a_q     <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= pend_v && (rise || down);
`ifdef EDGE_GEN_PENDING_EN
            pend_q  <= 1'b0;
`endif
          end else begin
            state_q <= LOW_IDLE;
            busy_q  <= 1'b0;
            err_q   <= rise || down;
          end
        end
      endcase
    end
  end

  assign bus.a    = a_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen.
// Status packed as {a,busy,done,err}.
module tb_edge_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef EDGE_GEN_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  edge_gen_if bus ();
  edge_gen_if bus1 ();

  edge_gen #(
    .MIN_HIGH(4),
    .MIN_LOW (3),
    .CNT_W   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  edge_gen #(
    .MIN_HIGH(1),
    .MIN_LOW (1),
    .CNT_W   (8)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [3:0] got, logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] st0();
    return {bus.a, bus.busy, bus.done, bus.err};
  endfunction

  function automatic logic [3:0] st1();
    return {bus1.a, bus1.busy, bus1.done, bus1.err};
  endfunction

  task automatic tick(logic r, logic d);
    bus.rise_req  = r;
    bus.down_req  = d;
    bus1.rise_req = r;
    bus1.down_req = d;
    @(posedge clk);
    #1;
    bus.rise_req  = 1'b0;
    bus.down_req  = 1'b0;
    bus1.rise_req = 1'b0;
    bus1.down_req = 1'b0;
  endtask

  initial begin
    bus.rise_req  = 1'b0;
    bus.down_req  = 1'b0;
    bus1.rise_req = 1'b0;
    bus1.down_req = 1'b0;

    // reset with a request present: ignored
    rst = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("rst", st0(), 4'b0000);
    rst = 1'b0;

    // rise right after release, hold 4 cycles
    tick(1'b1, 1'b0);
    check("rise", st0(), 4'b1110);
    tick(1'b0, 1'b0);
    check("hh1", st0(), 4'b1100);
    tick(1'b0, 1'b0);
    check("hh2", st0(), 4'b1100);
    tick(1'b0, 1'b0);
    check("hh3", st0(), 4'b1100);
    tick(1'b0, 1'b0);
    check("hidle", st0(), 4'b1000);

    // rise in HIGH_IDLE rejected
    tick(1'b1, 1'b0);
    check("hi_rise", st0(), 4'b1001);
    tick(1'b0, 1'b0);
    check("hi_rise2", st0(), 4'b1000);

    // fall, hold 3 cycles
    tick(1'b0, 1'b1);
    check("down", st0(), 4'b0110);
    tick(1'b0, 1'b0);
    check("lh1", st0(), 4'b0100);
    tick(1'b0, 1'b0);
    check("lh2", st0(), 4'b0100);
    tick(1'b0, 1'b0);
    check("lidle", st0(), 4'b0000);

    // both together, then down in LOW_IDLE
    tick(1'b1, 1'b1);
    check("both", st0(), 4'b0001);
    tick(1'b0, 1'b0);
    check("both2", st0(), 4'b0000);
    tick(1'b0, 1'b1);
    check("lo_down", st0(), 4'b0001);

    // down during HIGH_HOLD, then a second one
    tick(1'b1, 1'b0);
    check("p_rise", st0(), 4'b1110);
    tick(1'b0, 1'b0);
    check("p_h1", st0(), 4'b1100);
    tick(1'b0, 1'b1);
    check("p_req", st0(), PEND ? 4'b1100 : 4'b1101);
    tick(1'b0, 1'b1);
    check("p_req2", st0(), 4'b1101);
    tick(1'b0, 1'b0);
    check("p_edge", st0(), PEND ? 4'b0110 : 4'b1000);
    if (!PEND) begin
      tick(1'b0, 1'b0);
      check("np_stay", st0(), 4'b1000);
      tick(1'b0, 1'b1);
      check("np_down", st0(), 4'b0110);
    end
    tick(1'b0, 1'b0);
    check("p_l1", st0(), 4'b0100);
    tick(1'b0, 1'b0);
    check("p_l2", st0(), 4'b0100);
    tick(1'b0, 1'b0);
    check("p_lidle", st0(), 4'b0000);

    // reset during HIGH_HOLD with a request pending
    tick(1'b1, 1'b0);
    check("r_rise", st0(), 4'b1110);
    tick(1'b0, 1'b1);
    check("r_req", st0(), PEND ? 4'b1100 : 4'b1101);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    check("r_rst", st0(), 4'b0000);
    rst = 1'b0;
    tick(1'b0, 1'b0);
    check("r_after", st0(), 4'b0000);
    // pending must be gone: full hold then HIGH_IDLE
    tick(1'b1, 1'b0);
    check("r_rise2", st0(), 4'b1110);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("r_h3", st0(), 4'b1100);
    tick(1'b0, 1'b0);
    check("r_hidle", st0(), 4'b1000);

    // MIN=1: back-to-back toggles
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    check("m1_rst", st1(), 4'b0000);
    tick(1'b1, 1'b0);
    check("m1_rise", st1(), 4'b1110);
    tick(1'b0, 1'b1);
    check("m1_down", st1(), 4'b0110);
    tick(1'b1, 1'b0);
    check("m1_rise2", st1(), 4'b1110);
    tick(1'b0, 1'b0);
    check("m1_idle", st1(), 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_gen.md
EDGE_GEN -- requirements
Module: edge_gen

Interface
REQ-001 SHALL have parameter MIN_HIGH, default 4: minimum cycles output a stays high after a rising edge (legal range 1..2^CNT_W).
REQ-002 SHALL have parameter MIN_LOW, default 4: minimum cycles output a stays low after a falling edge (legal range 1..2^CNT_W).
REQ-003 SHALL have parameter CNT_W, default 8: hold counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rise_req  input  1  single-cycle request for a rising edge on a.
REQ-007 SHALL have port down_req  input  1  single-cycle request for a falling edge on a.
REQ-008 SHALL have port a  output  1  registered generated level.
REQ-009 SHALL have port busy  output  1  high while a hold interval is running or a request is pending.
REQ-010 SHALL have port done  output  1  one-cycle pulse in the first cycle a shows a new level.
REQ-011 SHALL have port err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-012 SHALL implement the states LOW_IDLE, HIGH_HOLD, HIGH_IDLE and LOW_HOLD.
REQ-013 In LOW_IDLE, rise_req at cycle N SHALL give a=1 and done=1 at N+1, load the counter with MIN_HIGH-1 and enter HIGH_HOLD.
REQ-014 In HIGH_IDLE, down_req at cycle N SHALL give a=0 and done=1 at N+1, load the counter with MIN_LOW-1 and enter LOW_HOLD.
REQ-015 In a HOLD state the counter SHALL decrement by one each cycle; when it is 0, the state SHALL move to the matching IDLE state on the next cycle, or serve the pending request (REQ-019).
REQ-016 a SHALL stay at each new level for at least MIN_HIGH or MIN_LOW cycles; with MIN_x=1 a back-to-back opposite request SHALL toggle a on consecutive cycles.
REQ-017 rise_req and down_req both high in the same cycle SHALL pulse err next cycle and be ignored entirely.
REQ-018 A request for the level a already has or is heading to (for example rise_req in HIGH_IDLE or HIGH_HOLD) SHALL pulse err and be ignored.
REQ-019 Pending-request handling SHALL follow REQ-026/REQ-027.
REQ-020 busy SHALL equal (state is HIGH_HOLD or LOW_HOLD) OR pending-valid.
REQ-021 done and err SHALL never be high for more than one consecutive cycle per event; done and err SHALL be able to assert in the same cycle when their events coincide.

Reset
REQ-022 While rst=1 at a clock edge, the next state SHALL be LOW_IDLE with a=0, busy=0, done=0, err=0, counter=0 and the pending request cleared.
REQ-023 Reset asserted mid-hold or with a request pending SHALL abort it with no done or err pulse.
REQ-024 Requests in the same cycle as rst=1 SHALL be ignored.
REQ-025 In the first cycle after reset release, a rise_req SHALL be served normally per REQ-013.

Configuration
REQ-026 With macro EDGE_GEN_PENDING_EN defined, one opposite-direction request arriving during a HOLD state SHALL be latched; when the counter reaches 0, the edge SHALL occur on the next cycle (a held exactly MIN_x cycles), and a second request while one is pending SHALL pulse err and be dropped.
REQ-027 Without EDGE_GEN_PENDING_EN, any request during a HOLD state SHALL pulse err and be dropped; no pending register SHALL be implemented and busy SHALL reflect HOLD states only.

Verification (MIN_HIGH=4, MIN_LOW=3)
REQ-028 Reset then rise_req at cycle 10 -> a=1 and done=1 at cycle 11; busy 11..14; down_req at 20 -> a=0 and done at 21; busy 21..23.
REQ-029 rise_req and down_req together at cycle 5 in LOW_IDLE -> err at 6; a stays 0; no done.
REQ-030 With EDGE_GEN_PENDING_EN: rise_req at 10, down_req at 12 -> a=1 on cycles 11..14, a=0 at 15 with done; a second down_req at 13 -> err at 14.
REQ-031 Without EDGE_GEN_PENDING_EN: same stimulus as REQ-030 -> err at 13; a stays 1 until a later down_req in HIGH_IDLE.
REQ-032 rst=1 at cycle 12 during HIGH_HOLD with a down request pending -> a=0 at 13; state LOW_IDLE; busy=0; no done or err.
REQ-033 rise_req in HIGH_IDLE -> err pulse; a unchanged; busy stays 0.
